// File: rtl/accelerator_tensor_stream_indexer_if.sv
// Stream bus between the tensor element source and the indexer: start/sizes in,
// framed element stream and completion pulse out.
`timescale 1ns/1ps
interface accelerator_tensor_stream_indexer_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] SIZE_K_IN;
  logic                 DATA_IN_ENABLE;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic                 DATA_OUT_I_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic                 DATA_OUT_K_ENABLE;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic [DATA_SIZE-1:0] INDEX_I_OUT;
  logic [DATA_SIZE-1:0] INDEX_J_OUT;
  logic [DATA_SIZE-1:0] INDEX_K_OUT;

  modport master (
    output START, SIZE_I_IN, SIZE_J_IN, SIZE_K_IN, DATA_IN_ENABLE, DATA_IN,
    input  READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE,
           DATA_OUT, INDEX_I_OUT, INDEX_J_OUT, INDEX_K_OUT
  );

  modport slave (
    input  START, SIZE_I_IN, SIZE_J_IN, SIZE_K_IN, DATA_IN_ENABLE, DATA_IN,
    output READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE,
           DATA_OUT, INDEX_I_OUT, INDEX_J_OUT, INDEX_K_OUT
  );
endinterface

// File: rtl/accelerator_tensor_stream_indexer.sv
// Re-emits a row-major (k fastest) element stream with I/J/K framing strobes and
// (i,j,k) indices, and pulses READY with the last element of the tensor.
`timescale 1ns/1ps
module accelerator_tensor_stream_indexer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  accelerator_tensor_stream_indexer_if.slave     bus
);

  localparam logic [DATA_SIZE-1:0] One = DATA_SIZE'(1);

  if (CONTROL_SIZE < 2) begin : gControlTooNarrow
    $error("CONTROL_SIZE must be wide enough to hold the 2-bit state code");
  end

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    INPUT_STATE   = 2'd1,
    ENDER_STATE   = 2'd2
  } state_e;

  state_e               state_q;
  logic [DATA_SIZE-1:0] sizeI_q, sizeJ_q, sizeK_q;
  logic [DATA_SIZE-1:0] i_q, j_q, k_q;
  logic [DATA_SIZE-1:0] i_d, j_d, k_d;
  logic                 kWrap, jWrap, iWrap, lastElem, anyZero;

  logic                 ready_q;
  logic                 iEn_q, jEn_q, kEn_q;
  logic [DATA_SIZE-1:0] dataOut_q;
  logic [DATA_SIZE-1:0] idxI_q, idxJ_q, idxK_q;

  // Nested wrap: k fastest, then j, then i; the full wrap marks the last element.
  always_comb begin
    kWrap    = (k_q == sizeK_q - One);
    jWrap    = (j_q == sizeJ_q - One);
    iWrap    = (i_q == sizeI_q - One);
    lastElem = kWrap && jWrap && iWrap;
    k_d      = kWrap ? '0 : k_q + One;
    j_d      = kWrap ? (jWrap ? '0 : j_q + One) : j_q;
    i_d      = (kWrap && jWrap) ? (iWrap ? '0 : i_q + One) : i_q;
    anyZero  = (bus.SIZE_I_IN == '0) || (bus.SIZE_J_IN == '0) || (bus.SIZE_K_IN == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= STARTER_STATE;
      sizeI_q   <= '0;
      sizeJ_q   <= '0;
      sizeK_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ready_q   <= 1'b0;
      iEn_q     <= 1'b0;
      jEn_q     <= 1'b0;
      kEn_q     <= 1'b0;
      dataOut_q <= '0;
      idxI_q    <= '0;
      idxJ_q    <= '0;
      idxK_q    <= '0;
    end else begin
      case (state_q)
        STARTER_STATE: begin
          ready_q <= 1'b0;
          iEn_q   <= 1'b0;
          jEn_q   <= 1'b0;
          kEn_q   <= 1'b0;
          if (bus.START) begin
            sizeI_q <= bus.SIZE_I_IN;
            sizeJ_q <= bus.SIZE_J_IN;
            sizeK_q <= bus.SIZE_K_IN;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            // An empty tensor completes straight away.
            if (anyZero) begin
              state_q <= ENDER_STATE;
              ready_q <= 1'b1;
            end else begin
              state_q <= INPUT_STATE;
            end
          end
        end

        INPUT_STATE: begin
          if (bus.DATA_IN_ENABLE) begin
            dataOut_q <= bus.DATA_IN;
            idxI_q    <= i_q;
            idxJ_q    <= j_q;
            idxK_q    <= k_q;
            kEn_q     <= 1'b1;
            jEn_q     <= (k_q == '0);
            iEn_q     <= (j_q == '0) && (k_q == '0);
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            // READY rides along with the last element's strobes.
            if (lastElem) begin
              state_q <= ENDER_STATE;
              ready_q <= 1'b1;
            end
          end else begin
            iEn_q <= 1'b0;
            jEn_q <= 1'b0;
            kEn_q <= 1'b0;
          end
        end

        ENDER_STATE: begin
          ready_q <= 1'b0;
          iEn_q   <= 1'b0;
          jEn_q   <= 1'b0;
          kEn_q   <= 1'b0;
          state_q <= STARTER_STATE;
        end

        default: begin
          ready_q <= 1'b0;
          iEn_q   <= 1'b0;
          jEn_q   <= 1'b0;
          kEn_q   <= 1'b0;
          state_q <= STARTER_STATE;
        end
      endcase
    end
  end

  assign bus.READY             = ready_q;
  assign bus.DATA_OUT_I_ENABLE = iEn_q;
  assign bus.DATA_OUT_J_ENABLE = jEn_q;
  assign bus.DATA_OUT_K_ENABLE = kEn_q;
  assign bus.DATA_OUT          = dataOut_q;
  assign bus.INDEX_I_OUT       = idxI_q;
  assign bus.INDEX_J_OUT       = idxJ_q;
  assign bus.INDEX_K_OUT       = idxK_q;

endmodule

// File: tb/tb_accelerator_tensor_stream_indexer.sv
// Directed bench for the tensor stream indexer; expected elements are queued from a
// linear-count position model as they are driven and compared when they emerge.
`timescale 1ns/1ps
module tb_accelerator_tensor_stream_indexer;

  localparam int DW = 64;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  accelerator_tensor_stream_indexer_if #(.DATA_SIZE(DW)) bus ();

  accelerator_tensor_stream_indexer #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] i;
    logic [DW-1:0] j;
    logic [DW-1:0] k;
    logic          ie;
    logic          je;
    logic          last;
  } exp_t;

  exp_t          scoreQ[$];
  int            checks     = 0;
  int            failures   = 0;
  int            readyCount = 0;
  int            expReady   = 0;
  logic          mArmed     = 1'b0;
  logic [DW-1:0] mCount, mSI, mSJ, mSK;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Position comes from the element's linear ordinal, not from wrapping counters.
  task automatic applyStimulus(input logic en, input logic [DW-1:0] d);
    exp_t e;
    @(negedge CLK);
    bus.START          = 1'b0;
    bus.DATA_IN_ENABLE = en;
    bus.DATA_IN        = d;
    bus.SIZE_I_IN      = {$urandom(), $urandom()};
    bus.SIZE_J_IN      = {$urandom(), $urandom()};
    bus.SIZE_K_IN      = {$urandom(), $urandom()};
    if (en && mArmed) begin
      e.data = d;
      e.k    = mCount % mSK;
      e.j    = (mCount / mSK) % mSJ;
      e.i    = mCount / (mSJ * mSK);
      e.je   = (e.k == '0);
      e.ie   = (e.k == '0) && (e.j == '0);
      e.last = (mCount == mSI * mSJ * mSK - 64'd1);
      scoreQ.push_back(e);
      mCount++;
      if (e.last) mArmed = 1'b0;
    end
  endtask

  task automatic startOp(input logic [DW-1:0] si, input logic [DW-1:0] sj, input logic [DW-1:0] sk,
                         input logic en, input logic [DW-1:0] d);
    @(negedge CLK);
    bus.START          = 1'b1;
    bus.SIZE_I_IN      = si;
    bus.SIZE_J_IN      = sj;
    bus.SIZE_K_IN      = sk;
    bus.DATA_IN_ENABLE = en;
    bus.DATA_IN        = d;
    if (!mArmed) begin
      mSI    = si;
      mSJ    = sj;
      mSK    = sk;
      mCount = '0;
      mArmed = (si != '0) && (sj != '0) && (sk != '0);
    end
  endtask

  // Every emitted element must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.READY) readyCount++;
      if (bus.DATA_OUT_K_ENABLE) begin
        checkBit("output_expected", scoreQ.size() != 0, 1'b1);
        if (scoreQ.size() != 0) begin
          exp_t e;
          e = scoreQ.pop_front();
          checkOutput("data_out", bus.DATA_OUT, e.data);
          checkOutput("index_i", bus.INDEX_I_OUT, e.i);
          checkOutput("index_j", bus.INDEX_J_OUT, e.j);
          checkOutput("index_k", bus.INDEX_K_OUT, e.k);
          checkBit("i_enable", bus.DATA_OUT_I_ENABLE, e.ie);
          checkBit("j_enable", bus.DATA_OUT_J_ENABLE, e.je);
          checkBit("ready_with_elem", bus.READY, e.last);
        end
      end else begin
        checkBit("idle_i_enable", bus.DATA_OUT_I_ENABLE, 1'b0);
        checkBit("idle_j_enable", bus.DATA_OUT_J_ENABLE, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.START          = 1'b0;
    bus.SIZE_I_IN      = '0;
    bus.SIZE_J_IN      = '0;
    bus.SIZE_K_IN      = '0;
    bus.DATA_IN_ENABLE = 1'b0;
    bus.DATA_IN        = '0;

    repeat (2) @(negedge CLK);
    checkBit("rst_ready", bus.READY, 1'b0);
    checkBit("rst_k_enable", bus.DATA_OUT_K_ENABLE, 1'b0);
    checkBit("rst_j_enable", bus.DATA_OUT_J_ENABLE, 1'b0);
    checkBit("rst_i_enable", bus.DATA_OUT_I_ENABLE, 1'b0);
    checkOutput("rst_data_out", bus.DATA_OUT, 64'h0);
    checkOutput("rst_index_i", bus.INDEX_I_OUT, 64'h0);
    @(posedge CLK);
    #2 RST = 1'b1;

    $display("[TB] contiguous 2x2x3 stream");
    startOp(64'd2, 64'd2, 64'd3, 1'b1, 64'hDEAD);
    for (int v = 1; v <= 12; v++) applyStimulus(1'b1, DW'(v));
    repeat (3) applyStimulus(1'b0, '0);
    expReady++;
    checkOutput("t1_ready_count", DW'(readyCount), DW'(expReady));
    checkOutput("t1_drained", DW'(scoreQ.size()), 64'h0);

    $display("[TB] gapped 2x2x3 stream");
    startOp(64'd2, 64'd2, 64'd3, 1'b0, '0);
    for (int v = 1; v <= 12; v++) begin
      applyStimulus(1'b1, DW'(100 + v));
      if (v > 1) begin
        checkOutput("t2_hold_data", bus.DATA_OUT, DW'(100 + v - 1));
        checkBit("t2_gap_k_enable", bus.DATA_OUT_K_ENABLE, 1'b0);
      end
      if (v == 6) checkOutput("t2_no_early_ready", DW'(readyCount), DW'(expReady));
      applyStimulus(1'b0, '0);
    end
    repeat (3) applyStimulus(1'b0, '0);
    expReady++;
    checkOutput("t2_ready_count", DW'(readyCount), DW'(expReady));
    checkOutput("t2_drained", DW'(scoreQ.size()), 64'h0);

    $display("[TB] single element 1x1x1");
    startOp(64'd1, 64'd1, 64'd1, 1'b0, '0);
    applyStimulus(1'b1, 64'hAB);
    applyStimulus(1'b0, '0);
    checkOutput("t3_data", bus.DATA_OUT, 64'hAB);
    checkBit("t3_i_enable", bus.DATA_OUT_I_ENABLE, 1'b1);
    checkBit("t3_j_enable", bus.DATA_OUT_J_ENABLE, 1'b1);
    checkBit("t3_k_enable", bus.DATA_OUT_K_ENABLE, 1'b1);
    checkBit("t3_ready", bus.READY, 1'b1);
    repeat (2) applyStimulus(1'b0, '0);
    expReady++;
    checkOutput("t3_ready_count", DW'(readyCount), DW'(expReady));

    $display("[TB] zero-size J axis");
    startOp(64'd3, 64'd0, 64'd2, 1'b0, '0);
    applyStimulus(1'b1, 64'h55);
    checkBit("t4_ready", bus.READY, 1'b1);
    checkBit("t4_k_enable", bus.DATA_OUT_K_ENABLE, 1'b0);
    applyStimulus(1'b1, 64'h56);
    checkBit("t4_ready_drop", bus.READY, 1'b0);
    checkBit("t4_k_enable_after", bus.DATA_OUT_K_ENABLE, 1'b0);
    repeat (2) applyStimulus(1'b0, '0);
    checkBit("t4_k_enable_idle", bus.DATA_OUT_K_ENABLE, 1'b0);
    expReady++;
    checkOutput("t4_ready_count", DW'(readyCount), DW'(expReady));

    $display("[TB] asynchronous reset mid-transfer");
    startOp(64'd2, 64'd2, 64'd2, 1'b0, '0);
    for (int v = 1; v <= 5; v++) applyStimulus(1'b1, DW'(32 + v));
    applyStimulus(1'b0, '0);
    #2 RST = 1'b0;
    #1;
    checkOutput("t5_rst_data", bus.DATA_OUT, 64'h0);
    checkOutput("t5_rst_index_k", bus.INDEX_K_OUT, 64'h0);
    checkBit("t5_rst_k_enable", bus.DATA_OUT_K_ENABLE, 1'b0);
    checkBit("t5_rst_ready", bus.READY, 1'b0);
    scoreQ.delete();
    mArmed = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    checkOutput("t5_no_ready", DW'(readyCount), DW'(expReady));
    startOp(64'd1, 64'd1, 64'd2, 1'b0, '0);
    applyStimulus(1'b1, 64'h11);
    applyStimulus(1'b1, 64'h22);
    repeat (3) applyStimulus(1'b0, '0);
    expReady++;
    checkOutput("t5_ready_count", DW'(readyCount), DW'(expReady));
    checkOutput("t5_drained", DW'(scoreQ.size()), 64'h0);

    $display("[TB] START ignored mid-transfer");
    startOp(64'd2, 64'd1, 64'd2, 1'b0, '0);
    applyStimulus(1'b1, 64'h71);
    applyStimulus(1'b1, 64'h72);
    startOp(64'd3, 64'd3, 64'd3, 1'b0, '0);
    applyStimulus(1'b1, 64'h73);
    applyStimulus(1'b1, 64'h74);
    repeat (3) applyStimulus(1'b0, '0);
    expReady++;
    checkOutput("t6_ready_count", DW'(readyCount), DW'(expReady));
    checkOutput("t6_drained", DW'(scoreQ.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accelerator_tensor_stream_indexer.md
Name: accelerator_tensor_stream_indexer

Overview:
- Upstream feeder for the tensor-by-matrix product and the other tensor operators.
- Accepts a flat, row-major stream of tensor elements from the memory or controller side.
- Re-emits each element with the I/J/K framing strobes those operators consume on their DATA_*_IN_I/J/K_ENABLE inputs.
- Tracks the (i,j,k) position with counters, checks the element count against the latched sizes, and signals completion with a READY pulse.

Parameters:
- DATA_SIZE, 64, width of data words and of the size/index fields.
- CONTROL_SIZE, 4, width of the internal control fields; kept for interface uniformity with sibling blocks.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RST  input  1  reset, asynchronous and active-low. RST==0 resets the block immediately, independent of CLK.
- START  input  1  one-cycle pulse; latches the sizes and arms the block.
- READY  output  1  one-cycle pulse when the last element has been emitted.
- SIZE_I_IN  input  DATA_SIZE  tensor extent along i.
- SIZE_J_IN  input  DATA_SIZE  tensor extent along j.
- SIZE_K_IN  input  DATA_SIZE  tensor extent along k.
- DATA_IN_ENABLE  input  1  DATA_IN is valid this cycle.
- DATA_IN  input  DATA_SIZE  element value, presented row-major with k fastest.
- DATA_OUT_I_ENABLE  output  1  marks the first element of each i-slice (j==0, k==0).
- DATA_OUT_J_ENABLE  output  1  marks the first element of each j-row (k==0).
- DATA_OUT_K_ENABLE  output  1  DATA_OUT is valid (every element).
- DATA_OUT  output  DATA_SIZE  registered copy of DATA_IN.
- INDEX_I_OUT  output  DATA_SIZE  i index of the current DATA_OUT.
- INDEX_J_OUT  output  DATA_SIZE  j index of the current DATA_OUT.
- INDEX_K_OUT  output  DATA_SIZE  k index of the current DATA_OUT.

Behaviour:
- Reset values: READY=0, all *_ENABLE=0, DATA_OUT=0, all INDEX_*=0. Reset forces the FSM to STARTER_STATE and clears the counters and latched sizes.
- Reset mid-operation aborts the transfer with no READY pulse.
- FSM states: STARTER_STATE, INPUT_STATE, ENDER_STATE. Encoding is 2 bits; unused codes go to STARTER_STATE.
- STARTER_STATE:
  - READY=0 and all enables=0.
  - On START=1: latch the three sizes, clear i/j/k to 0.
  - If any size is 0, go to ENDER_STATE; otherwise go to INPUT_STATE.
  - DATA_IN_ENABLE is ignored in this state.
- INPUT_STATE, on a cycle with DATA_IN_ENABLE=1, the next cycle shows:
  - DATA_OUT=DATA_IN and INDEX_*=current i/j/k.
  - K_ENABLE=1.
  - J_ENABLE=(k==0).
  - I_ENABLE=(j==0 && k==0).
  - Latency is exactly 1 cycle. Throughput is 1 element/cycle with no backpressure.
- Counter update per accepted element:
  - k increments.
  - When k==SIZE_K-1: k wraps to 0 and j increments.
  - When j also ==SIZE_J-1: j wraps to 0 and i increments.
  - When i==SIZE_I-1 as well (last element): go to ENDER_STATE.
- Cycles with DATA_IN_ENABLE=0 drive all enables to 0. DATA_OUT and INDEX_* hold their last values.
- ENDER_STATE:
  - READY=1 for exactly one cycle, then return to STARTER_STATE.
  - On a last-element path, READY is asserted in the same cycle as that element's K_ENABLE output.
  - On a zero-size path, READY is asserted 1 cycle after START.
- START while not in STARTER_STATE is ignored. Sizes stay latched until the next accepted START.
- SIZE_*_IN may change after START without effect.
- Counters and size compares are unsigned DATA_SIZE-bit. Total count is SIZE_I*SIZE_J*SIZE_K, with no product register; the termination rule is the nested wrap above.
- A size of 1 on any axis makes that axis wrap every step, so its enable condition holds continuously along it.
- DATA_IN_ENABLE in the same cycle as START is not accepted.

Test Plan:
- Sizes 2,2,3, START, then 12 consecutive elements 1..12:
  - DATA_OUT reads 1..12 one cycle later.
  - K_ENABLE is high on all 12.
  - J_ENABLE is high on elements 1,4,7,10.
  - I_ENABLE is high on elements 1,7.
  - INDEX of element 8 is (1,0,1).
  - READY pulses once, coincident with element 12.
- Same sizes, DATA_IN_ENABLE toggled 1,0,1,0…:
  - Enables are high only on the output cycles following accepted elements.
  - DATA_OUT holds during gaps.
  - READY occurs after the 12th accepted element, not after 12 cycles.
- Sizes 1,1,1, START, one element 0xAB:
  - DATA_OUT=0xAB with I, J and K enables all high in the same cycle as READY=1.
- SIZE_J=0, START:
  - READY pulses 1 cycle later.
  - No enable is ever asserted.
  - Returns to STARTER_STATE.
- Sizes 2,2,2, RST driven low asynchronously after 5 elements:
  - All outputs drop to 0 immediately and no READY pulse occurs.
  - A new START with sizes 1,1,2 and 2 elements completes normally.
- START pulsed again mid-transfer with different sizes:
  - Ignored; indexing follows the original sizes and READY arrives at the original count.
